// File: rtl/solver_state_reader.sv
// Decimating capture of solver current/speed words into a sequence-tagged
// first-word-fall-through FIFO, presented on a valid/ready stream.
module solver_state_reader #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int DECIM_W    = 16,
  parameter int SEQ_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DECIM_W-1:0]            decim,
  input  logic                          upd,
  input  logic [DATA_W-1:0]             i_in,
  input  logic [DATA_W-1:0]             w_in,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_W-1:0]             m_i,
  output logic [DATA_W-1:0]             m_w,
  output logic [SEQ_W-1:0]              m_seq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_cnt,
  input  logic                          clear_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1'b1);
  localparam logic [LW-1:0] LEVEL_ZERO = LW'(1'b0);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);

  logic [DECIM_W-1:0] dcnt;
  logic [SEQ_W-1:0]   seq;
  logic               cap_valid;
  logic [DATA_W-1:0]  cap_i;
  logic [DATA_W-1:0]  cap_w;
  logic [SEQ_W-1:0]   cap_seq;

  logic [DATA_W-1:0]  mem_i   [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_w   [FIFO_DEPTH];
  logic [SEQ_W-1:0]   mem_seq [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  logic               capture;
  logic               pop;
  logic               push;
  logic               drop;
  logic [LW-1:0]      level_next;
  logic [AW-1:0]      rd_next;
  logic               head_from_cap;

  // Capture decision, push/pop arbitration and next FIFO occupancy
  always_comb begin
    capture       = en & upd & (dcnt == {DECIM_W{1'b0}});
    pop           = m_valid & m_ready;
    push          = cap_valid & ((fifo_level != LEVEL_FULL) | pop);
    drop          = cap_valid & ~push;
    level_next    = fifo_level;
    rd_next       = rd_ptr;
    case ({push, pop})
      2'b10:   level_next = fifo_level + LEVEL_ONE;
      2'b01:   level_next = fifo_level - LEVEL_ONE;
      default: level_next = fifo_level;
    endcase
    if (pop) begin
      rd_next = rd_ptr + PTR_ONE;
    end else begin
      rd_next = rd_ptr;
    end
    // The incoming record becomes the head when nothing older survives this edge.
    head_from_cap = (fifo_level == LEVEL_ZERO) | (pop & (fifo_level == LEVEL_ONE));
  end

  // Decimation down-counter; held at zero while disabled so the first strobe captures
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= {DECIM_W{1'b0}};
    end else if (!en) begin
      dcnt <= {DECIM_W{1'b0}};
    end else if (upd) begin
      if (dcnt == {DECIM_W{1'b0}}) begin
        dcnt <= decim;
      end else begin
        dcnt <= dcnt - {{(DECIM_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Capture stage: tag every kept sample, stored or dropped later
  always_ff @(posedge clk) begin
    if (rst) begin
      seq       <= {SEQ_W{1'b0}};
      cap_valid <= 1'b0;
      cap_i     <= {DATA_W{1'b0}};
      cap_w     <= {DATA_W{1'b0}};
      cap_seq   <= {SEQ_W{1'b0}};
    end else begin
      cap_valid <= capture;
      if (capture) begin
        seq     <= seq + {{(SEQ_W-1){1'b0}}, 1'b1};
        cap_i   <= i_in;
        cap_w   <= w_in;
        cap_seq <= seq;
      end
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem_i[wr_ptr]   <= cap_i;
      mem_w[wr_ptr]   <= cap_w;
      mem_seq[wr_ptr] <= cap_seq;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      fifo_level <= LEVEL_ZERO;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr     <= rd_next;
      fifo_level <= level_next;
    end
  end

  // Registered head-of-FIFO view; holds last popped record when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_i     <= {DATA_W{1'b0}};
      m_w     <= {DATA_W{1'b0}};
      m_seq   <= {SEQ_W{1'b0}};
    end else begin
      m_valid <= (level_next != LEVEL_ZERO);
      if (level_next != LEVEL_ZERO) begin
        if (head_from_cap) begin
          m_i   <= cap_i;
          m_w   <= cap_w;
          m_seq <= cap_seq;
        end else begin
          m_i   <= mem_i[rd_next];
          m_w   <= mem_w[rd_next];
          m_seq <= mem_seq[rd_next];
        end
      end
    end
  end

  // Saturating drop counter; a clear coincident with a drop leaves one
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_cnt <= 16'h0000;
    end else if (clear_ovf) begin
      overflow_cnt <= drop ? 16'h0001 : 16'h0000;
    end else if (drop && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_solver_state_reader.sv
// Directed bench for solver_state_reader: queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_solver_state_reader;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int DECIM_W = 16;
  localparam int SEQ_W  = 16;

  logic               clk = 1'b0;
  logic               rst, en, upd, m_ready, clear_ovf, m_valid;
  logic [DECIM_W-1:0] decim;
  logic [DATA_W-1:0]  i_in, w_in, m_i, m_w;
  logic [SEQ_W-1:0]   m_seq;
  logic [3:0]         fifo_level;
  logic [15:0]        overflow_cnt;

  always #5 clk = ~clk;

  solver_state_reader #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .DECIM_W(DECIM_W), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .en(en), .decim(decim), .upd(upd), .i_in(i_in), .w_in(w_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_i(m_i), .m_w(m_w), .m_seq(m_seq),
    .fifo_level(fifo_level), .overflow_cnt(overflow_cnt), .clear_ovf(clear_ovf)
  );

  typedef struct {
    logic [15:0] seq;
    logic [63:0] i;
    logic [63:0] w;
  } rec_t;

  int   n_checks = 0;
  int   n_fail   = 0;

  rec_t mq[$];
  rec_t dlog[$];
  rec_t last_rec;
  rec_t pend_rec;
  bit   pend;
  bit   started = 1'b0;
  int   skip;
  int   mseq;
  int   movf;

  int   exp_dec_i[6] = '{0, 4, 8, 12, 14, 16};
  int   exp_ovf_seq[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 10};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input int eseq, input int ei, input int ew);
    if (idx >= dlog.size()) begin
      chk({name, "_len"}, 64'(dlog.size()), 64'(idx + 1));
    end else begin
      chk({name, "_seq"}, 64'(dlog[idx].seq), 64'(eseq));
      chk({name, "_i"}, dlog[idx].i, 64'(ei));
      chk({name, "_w"}, dlog[idx].w, 64'(ew));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: one step per rising edge, from the sampled inputs
  task automatic model_step();
    rec_t nr;
    bit   pop_m, drop_m, new_cap;
    nr = '{16'h0000, 64'h0, 64'h0};
    if (rst) begin
      mq.delete();
      last_rec = '{16'h0000, 64'h0, 64'h0};
      pend = 1'b0;
      skip = 0;
      mseq = 0;
      movf = 0;
      started = 1'b1;
    end else begin
      pop_m = (mq.size() != 0) && m_ready;
      if (pop_m) last_rec = mq.pop_front();
      drop_m = 1'b0;
      if (pend) begin
        if (mq.size() < DEPTH) mq.push_back(pend_rec);
        else drop_m = 1'b1;
      end
      if (clear_ovf) movf = drop_m ? 1 : 0;
      else if (drop_m && movf < 65535) movf++;
      new_cap = 1'b0;
      if (!en) begin
        skip = 0;
      end else if (upd) begin
        if (skip == 0) begin
          new_cap = 1'b1;
          nr.seq = 16'(mseq);
          nr.i = i_in;
          nr.w = w_in;
          mseq = (mseq + 1) % 65536;
          skip = int'(decim);
        end else begin
          skip--;
        end
      end
      pend = new_cap;
      pend_rec = nr;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: DUT outputs against the model on every falling edge
  initial forever begin
    rec_t hd;
    bit   ev;
    @(negedge clk);
    if (started) begin
      ev = (mq.size() != 0);
      hd = ev ? mq[0] : last_rec;
      chk("m_valid", 64'(m_valid), 64'(ev));
      chk("m_i", m_i, hd.i);
      chk("m_w", m_w, hd.w);
      chk("m_seq", 64'(m_seq), 64'(hd.seq));
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      chk("overflow_cnt", 64'(overflow_cnt), 64'(movf));
      if (!rst && m_valid && m_ready) dlog.push_back('{m_seq, m_i, m_w});
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; upd = 1'b0; decim = 16'd0; i_in = 64'h0; w_in = 64'h0;
    m_ready = 1'b0; clear_ovf = 1'b0;

    // Reset and idle with strobes while disabled
    tick(1); upd = 1'b1; tick(1); upd = 1'b0;
    rst = 1'b0;
    repeat (4) begin
      upd = 1'b1; i_in = 64'hDEAD; w_in = 64'hBEEF; tick(1); upd = 1'b0; tick(1);
    end
    chk("idle_valid", 64'(m_valid), 64'h0);
    chk("idle_level", 64'(fifo_level), 64'h0);
    chk("idle_ovf", 64'(overflow_cnt), 64'h0);
    chk("idle_i", m_i, 64'h0);
    chk("idle_w", m_w, 64'h0);
    chk("idle_seq", 64'(m_seq), 64'h0);

    // Basic capture, one-cycle latency
    dlog.delete(); en = 1'b1; decim = 16'd0; m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_in = 64'(32'h10 + k); w_in = 64'(32'h20 + k); upd = 1'b1;
      tick(1);
      chk("lat_pre", 64'(m_valid), 64'h0);
      upd = 1'b0;
      tick(1);
      chk("lat_post", 64'(m_valid), 64'h1);
      chk("basic_head_i", m_i, 64'(32'h10 + k));
    end
    tick(3);
    for (int k = 0; k < 3; k++) chk_log("basic", k, k, 32'h10 + k, 32'h20 + k);

    // Decimation by 4, then ratio change mid countdown
    rst = 1'b1; en = 1'b0; tick(1); rst = 1'b0;
    dlog.delete(); en = 1'b1; decim = 16'd3; m_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k == 10) decim = 16'd1;
      i_in = 64'(k); w_in = 64'(k + 100); upd = 1'b1; tick(1); upd = 1'b0; tick(1);
    end
    tick(3);
    for (int k = 0; k < 6; k++) chk_log("decim", k, k, exp_dec_i[k], exp_dec_i[k] + 100);

    // Overflow: 10 captures without a consumer
    rst = 1'b1; en = 1'b0; tick(1); rst = 1'b0;
    dlog.delete(); en = 1'b1; decim = 16'd0; m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i_in = 64'(32'h300 + k); w_in = 64'(32'h600 + k); upd = 1'b1; tick(1); upd = 1'b0; tick(1);
    end
    tick(2);
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_cnt", 64'(overflow_cnt), 64'd2);
    chk("ovf_head", 64'(m_seq), 64'd0);

    // Full FIFO with push and pop on the same edge
    i_in = 64'(32'h300 + 10); w_in = 64'(32'h600 + 10); upd = 1'b1; tick(1);
    upd = 1'b0; m_ready = 1'b1; tick(1); m_ready = 1'b0;
    chk("full_pp_level", 64'(fifo_level), 64'd8);
    chk("full_pp_ovf", 64'(overflow_cnt), 64'd2);
    chk("full_pp_head", 64'(m_seq), 64'd1);
    m_ready = 1'b1; tick(12); m_ready = 1'b0;
    chk("drain_level", 64'(fifo_level), 64'd0);
    for (int k = 0; k < 9; k++)
      chk_log("drain", k, exp_ovf_seq[k], 32'h300 + exp_ovf_seq[k], 32'h600 + exp_ovf_seq[k]);

    // Backpressure: head must stay put while more samples arrive
    rst = 1'b1; en = 1'b0; tick(1); rst = 1'b0;
    en = 1'b1; decim = 16'd0; m_ready = 1'b0;
    i_in = 64'h100; w_in = 64'h200; upd = 1'b1; tick(1); upd = 1'b0; tick(1);
    for (int c = 0; c < 20; c++) begin
      upd = (c % 2 == 0); i_in = 64'(32'h400 + c); w_in = 64'(32'h500 + c);
      tick(1);
      chk("hold_i", m_i, 64'h100);
      chk("hold_w", m_w, 64'h200);
      chk("hold_seq", 64'(m_seq), 64'h0);
    end
    upd = 1'b0;
    chk("bp_level", 64'(fifo_level), 64'd8);
    chk("bp_ovf", 64'(overflow_cnt), 64'd3);

    // Clear coincident with a drop leaves one
    upd = 1'b1; tick(1); upd = 1'b0; clear_ovf = 1'b1; tick(1); clear_ovf = 1'b0;
    chk("clear_with_drop", 64'(overflow_cnt), 64'd1);
    clear_ovf = 1'b1; tick(1); clear_ovf = 1'b0;
    chk("clear_plain", 64'(overflow_cnt), 64'd0);

    // Reset mid-stream discards contents and restarts tagging
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'h0);
    chk("rst_i", m_i, 64'h0);
    i_in = 64'h777; w_in = 64'h888; upd = 1'b1; tick(1); upd = 1'b0; tick(1);
    chk("post_rst_valid", 64'(m_valid), 64'h1);
    chk("post_rst_seq", 64'(m_seq), 64'h0);
    chk("post_rst_i", m_i, 64'h777);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
